// File: rtl/dir_conditioner_pkg.sv
// dir_pkg: shared bit indices and per-button FSM states for the direction conditioner
package dir_pkg;
    localparam int DIR_UP = 3;
    localparam int DIR_DOWN = 2;
    localparam int DIR_LEFT = 1;
    localparam int DIR_RIGHT = 0;
    typedef enum logic [1:0] {IDLE, WAIT, REPEAT, HOLD_NOREP} state_t;
endpackage

// File: rtl/dir_conditioner_if.sv
// dir_conditioner_if: raw buttons in, step pulses, held levels and conflict flags out
interface dir_conditioner_if;
    logic [3:0] btn_udlr;
    logic [3:0] step_udlr;
    logic [3:0] held_udlr;
    logic [1:0] conflict;
    modport master (output btn_udlr, input step_udlr, held_udlr, conflict);
    modport slave (input btn_udlr, output step_udlr, held_udlr, conflict);
endinterface

// File: rtl/dir_conditioner_debounce_bit.sv
// dir_debounce_bit: synchronise, debounce and auto-repeat one button, exposing next-state level and raw pulse
module dir_debounce_bit
    import dir_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int REPEAT_DELAY = 10000000,
    parameter int REPEAT_RATE = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic stable_next,
    output logic pulse
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);

    logic s1, s2, flip, rise, fall;
    logic [DW-1:0] cnt, cnt_next;
    logic [RW-1:0] rpt, rpt_next;
    state_t state, state_next;

    assign flip = (s2 != stable) && (cnt == DW'(DEB_CYCLES - 1));
    assign stable_next = flip ? s2 : stable;
    assign cnt_next = (s2 == stable || flip) ? '0 : cnt + DW'(1);
    assign rise = stable_next & ~stable;
    assign fall = ~stable_next & stable;

    // Repeat FSM evaluated on the next-state level so pulses line up with the stable flip; release wins
    always_comb begin
        state_next = state;
        rpt_next = rpt;
        pulse = 1'b0;
        if (fall) begin
            state_next = IDLE;
            rpt_next = '0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    pulse = 1'b1;
                    rpt_next = '0;
                    state_next = REPEAT_DELAY == 0 ? HOLD_NOREP : WAIT;
                end
                WAIT: begin
                    pulse = rpt == RW'(REPEAT_DELAY - 1);
                    rpt_next = pulse ? '0 : rpt + RW'(1);
                    state_next = pulse ? REPEAT : WAIT;
                end
                REPEAT: begin
                    pulse = rpt == RW'(REPEAT_RATE - 1);
                    rpt_next = pulse ? '0 : rpt + RW'(1);
                end
                default: ;
            endcase
        end
    end

    // Synchroniser, debounce and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            stable <= 1'b0;
            cnt <= '0;
            rpt <= '0;
            state <= IDLE;
        end else begin
            s1 <= btn;
            s2 <= s1;
            stable <= stable_next;
            cnt <= cnt_next;
            rpt <= rpt_next;
            state <= state_next;
        end
    end
endmodule

// File: rtl/dir_conditioner.sv
// dir_conditioner: four conditioned direction buttons with opposing-pair conflict masking
module dir_conditioner
    import dir_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int REPEAT_DELAY = 10000000,
    parameter int REPEAT_RATE = 2000000
) (
    input logic clk,
    input logic rst,
    dir_conditioner_if.slave bus
);
    logic [3:0] stable, stable_next, pulse, mask, step;
    logic [1:0] conflict, conflict_next;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        dir_debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE(REPEAT_RATE)
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .btn(bus.btn_udlr[i]),
            .stable(stable[i]),
            .stable_next(stable_next[i]),
            .pulse(pulse[i])
        );
    end

    assign conflict_next = {stable_next[DIR_UP] & stable_next[DIR_DOWN],
                            stable_next[DIR_LEFT] & stable_next[DIR_RIGHT]};
    assign mask = {conflict_next[1], conflict_next[1], conflict_next[0], conflict_next[0]};

    // Register masked steps and conflict flags alongside the stable levels they derive from
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            conflict <= '0;
        end else begin
            step <= pulse & ~mask;
            conflict <= conflict_next;
        end
    end

    assign bus.step_udlr = step;
    assign bus.held_udlr = stable;
    assign bus.conflict = conflict;
endmodule

// File: tb/tb_dir_conditioner.sv
// tb_dir_conditioner: directed stimulus with a step-pulse scoreboard and direct level checks
module tb_dir_conditioner;
    typedef struct {
        int cyc;
        logic [3:0] step;
    } exp_t;

    logic clk, rst;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    dir_conditioner_if bus ();

    dir_conditioner #(.DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the number of the latest rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input logic [3:0] s);
        exp_t e;
        e.cyc = c;
        e.step = s;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: flag missed pulses, then pop and compare whenever a step pulse appears
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_step expected at edge %0d value %b, no pulse observed", e.cyc, e.step);
            end
            if (bus.step_udlr != 4'b0000) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step at edge %0d: got %b want none", cyc, bus.step_udlr);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.step !== bus.step_udlr) begin
                        errors++;
                        $display("FAIL step at edge %0d: got %b want %b at edge %0d",
                                 cyc, bus.step_udlr, e.step, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int offs[6] = '{6, 26, 34, 42, 50, 58};
        rst = 1'b1;
        bus.btn_udlr = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            wait_n(1);
            chk("reset_step", bus.step_udlr, 4'b0000);
            chk("reset_held", bus.held_udlr, 4'b0000);
            chk("reset_conflict", bus.conflict, 2'b00);
        end
        rst = 1'b0;
        wait_n(10);
        chk("all_held", bus.held_udlr, 4'b1111);
        chk("all_conflict", bus.conflict, 2'b11);
        bus.btn_udlr = 4'b0000;
        wait_n(10);
        chk("all_released_held", bus.held_udlr, 4'b0000);
        chk("all_released_conflict", bus.conflict, 2'b00);

        base = cyc;
        bus.btn_udlr = 4'b0001;
        push(base + 6, 4'b0001);
        wait_n(5);
        chk("right_held_before", bus.held_udlr, 4'b0000);
        wait_n(1);
        chk("right_held_edge6", bus.held_udlr, 4'b0001);
        wait_n(4);
        bus.btn_udlr = 4'b0000;
        wait_n(5);
        chk("right_release_still_held", bus.held_udlr, 4'b0001);
        wait_n(1);
        chk("right_release_held", bus.held_udlr, 4'b0000);
        wait_n(5);

        bus.btn_udlr = 4'b1000;
        wait_n(3);
        bus.btn_udlr = 4'b0000;
        wait_n(1);
        bus.btn_udlr = 4'b1000;
        wait_n(3);
        bus.btn_udlr = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            wait_n(1);
            chk("glitch_held", bus.held_udlr, 4'b0000);
        end

        base = cyc;
        bus.btn_udlr = 4'b0100;
        foreach (offs[k]) push(base + offs[k], 4'b0100);
        wait_n(30);
        chk("down_held", bus.held_udlr, 4'b0100);
        wait_n(30);
        bus.btn_udlr = 4'b0000;
        wait_n(5);
        chk("down_release_still_held", bus.held_udlr, 4'b0100);
        wait_n(1);
        chk("down_release_held", bus.held_udlr, 4'b0000);
        wait_n(10);

        base = cyc;
        bus.btn_udlr = 4'b1000;
        push(base + 6, 4'b1000);
        push(base + 42, 4'b1000);
        push(base + 50, 4'b1000);
        wait_n(10);
        bus.btn_udlr = 4'b1100;
        wait_n(10);
        chk("updown_conflict", bus.conflict, 2'b10);
        chk("updown_held", bus.held_udlr, 4'b1100);
        wait_n(10);
        bus.btn_udlr = 4'b1000;
        wait_n(5);
        chk("updown_conflict_hold", bus.conflict, 2'b10);
        wait_n(1);
        chk("updown_conflict_clear", bus.conflict, 2'b00);
        wait_n(9);
        bus.btn_udlr = 4'b0000;
        wait_n(10);
        chk("up_released_held", bus.held_udlr, 4'b0000);

        base = cyc;
        bus.btn_udlr = 4'b1001;
        push(base + 6, 4'b1001);
        wait_n(10);
        chk("upright_held", bus.held_udlr, 4'b1001);
        rst = 1'b1;
        wait_n(1);
        bus.btn_udlr = 4'b0000;
        wait_n(1);
        chk("midreset_held", bus.held_udlr, 4'b0000);
        chk("midreset_step", bus.step_udlr, 4'b0000);
        rst = 1'b0;
        wait_n(40);
        chk("after_reset_held", bus.held_udlr, 4'b0000);

        wait_n(2);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dir_conditioner.md
Name: dir_conditioner

Overview:
- Upstream stage of the position tracker. Conditions the four raw direction buttons (ui_in[3:0], order up/down/left/right) before they reach it.
- Per button: two-flop synchronisation, debounce and auto-repeat.
- Drives one-cycle step pulses on step_udlr, which feeds the position tracker's dir_udlr input directly.
- Also exports clean held levels for status reporting over I2C.

Parameters:
- DEB_CYCLES, 50000: consecutive cycles a synchronised input must differ from the stable level before the stable level flips. Must be at least 1.
- REPEAT_DELAY, 10000000: cycles a button is held before its first auto-repeat pulse. 0 disables auto-repeat.
- REPEAT_RATE, 2000000: cycles between subsequent auto-repeat pulses. Must be at least 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset (top level drives it as ~rst_n)
- btn_udlr  input  4  raw asynchronous buttons, active high: [3]=up, [2]=down, [1]=left, [0]=right
- step_udlr  output  4  registered one-cycle move pulses, same bit order
- held_udlr  output  4  debounced stable levels, same bit order
- conflict  output  2  registered: [1]=up and down both held, [0]=left and right both held

Behaviour:
- Reset, sampled on a rising clk edge with rst=1:
  - sync flops, stable levels, held_udlr, step_udlr and conflict all go to 0.
  - All counters go to 0; every per-bit FSM goes to IDLE.
  - Reset mid-press discards the press. No pulse is emitted until the input has been released and re-pressed, or held through a full debounce window after reset.
- Synchroniser: s1 <= btn, then s2 <= s1.
- Debounce, per bit, counter width $clog2(DEB_CYCLES+1):
  - s2 == stable: cnt <= 0.
  - Otherwise, cnt == DEB_CYCLES-1: stable <= s2 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A glitch shorter than DEB_CYCLES consecutive cycles never changes stable.
  - held_udlr equals stable.
- Latency: raw is set before edge 1, then held. stable and the first step pulse both register at edge 2+DEB_CYCLES. The pulse is high for exactly one cycle.
- Per-bit FSM, with repeat counter rpt of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE: stable rising gives pulse=1, rpt <= 0, next state WAIT. If REPEAT_DELAY==0, stay in HOLD_NOREP instead, with no further pulses.
  - WAIT: rpt == REPEAT_DELAY-1 gives pulse=1, rpt <= 0, next state REPEAT. Otherwise rpt++.
  - REPEAT: rpt == REPEAT_RATE-1 gives pulse=1, rpt <= 0. Otherwise rpt++.
  - Any state: stable falling goes to IDLE with no pulse. Release has priority over a repeat pulse due in the same cycle.
- Pulse timing:
  - First repeat: REPEAT_DELAY cycles after the press pulse.
  - Then one pulse every REPEAT_RATE cycles.
- Conflict masking:
  - conflict[1] = held[3] & held[2]; conflict[0] = held[1] & held[0].
  - conflict is computed from the next-state stable values and registered with them.
  - step_udlr = pulse & ~{c1,c1,c0,c0}, where c1/c0 are that same next-state conflict.
  - Opposing buttons held together produce no steps on either bit, including repeat pulses.
  - Releasing one of the pair does not re-emit a press pulse for the other. The other's repeat timing continues from its FSM state.
- Independence:
  - Different axes are fully independent; simultaneous up+right presses pulse both bits in the same cycle.
  - Counters saturate nowhere; every counter is reloaded before it can wrap.

Decomposition:
- Package dir_pkg holds:
  - bit index constants DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0;
  - the FSM state enum IDLE/WAIT/REPEAT/HOLD_NOREP (2 bits).
- Sub-module dir_debounce_bit: synchroniser, debounce counter, FSM and raw pulse for one button, instantiated 4 times.
- Top module dir_conditioner adds conflict masking and output registering.

Test Plan:
All scenarios use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Reset with btn=4'b1111 held for 3 cycles -> all outputs 0 during reset. Steps go to 4'b0000 and conflict to 2'b11 once stable after release of rst: conflicts mask all four bits.
- btn[0] rises before edge 1 and is held 10 cycles -> step_udlr=4'b0001 only in the cycle after edge 6. held_udlr[0]=1 from edge 6. Release gives no pulse; held returns to 0 after 2+4 cycles.
- btn[3] glitch high for 3 cycles, twice, 1 cycle apart -> step and held stay 0 throughout.
- btn[2] held 60 cycles -> pulses at edges 6, 26, 34, 42, 50, 58. Release at cycle 60 gives no further pulse.
- btn[3] stable, then btn[2] pressed -> btn[2] emits no pulse and conflict[1]=1. btn[3] repeats are suppressed while both are held and resume on btn[3]'s own schedule after btn[2] is released.
- btn[3] and btn[0] pressed the same cycle -> step_udlr=4'b1001 in one cycle. Reset asserted during WAIT -> no repeat pulse ever appears for that press.
